// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions, FSM states.
// No logic, no latency.
// No backpressure.
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_SHIFT = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_XOR   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_CMP   = 3'b111;

    localparam int FLG_NEG  = 0;
    localparam int FLG_POS  = 1;
    localparam int FLG_ZERO = 2;
    localparam int FLG_OVF  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative datapath: one-bit-per-cycle shifter and magnitude shift-add multiplier.
// Latency: i_steps iterations; the first runs on the start edge, o_done flags the last.
// No backpressure; the parent holds off new starts while an operation is in flight.
import alu_pkg::*;

module alu_seq_iter #(
    parameter int WIDTH = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_mul,
    input  logic             i_left,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_steps,
    output logic [WIDTH-1:0] o_step1,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    acc_q, mcand_q, acc_nxt, prod;
    logic [WIDTH-1:0] mplier_q, cnt_q, mag_a, mag_b;
    logic             mul_q, left_q, neg_q;

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic left);
        return left ? {v[WIDTH-2:0], 1'b0} : {v[WIDTH-1], v[WIDTH-1:1]};
    endfunction

    assign o_step1 = shift1(i_a, i_left);
    assign mag_a   = i_a[WIDTH-1] ? -i_a : i_a;
    assign mag_b   = i_b[WIDTH-1] ? -i_b : i_b;

    // acc_nxt is the value after the current iteration; on the last one it is the answer.
    assign acc_nxt = mul_q ? acc_q + (mplier_q[0] ? mcand_q : '0)
                           : {{WIDTH{1'b0}}, shift1(acc_q[WIDTH-1:0], left_q)};
    assign prod     = neg_q ? -acc_nxt : acc_nxt;
    assign o_done   = (cnt_q == WIDTH'(1));
    assign o_result = mul_q ? prod[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    assign o_ovf    = mul_q && (prod[PW-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            mul_q    <= 1'b0;
            left_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else if (i_start) begin
            cnt_q  <= i_steps - 1'b1;
            mul_q  <= i_mul;
            left_q <= i_left;
            neg_q  <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            if (i_mul) begin
                acc_q    <= mag_b[0] ? {{WIDTH{1'b0}}, mag_a} : '0;
                mcand_q  <= {{WIDTH{1'b0}}, mag_a} << 1;
                mplier_q <= mag_b >> 1;
            end else begin
                acc_q    <= {{WIDTH{1'b0}}, o_step1};
                mcand_q  <= '0;
                mplier_q <= '0;
            end
        end else if (cnt_q != '0) begin
            acc_q    <= acc_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: registered result/flags, iterative SHIFT and signed MUL.
// Latency: 1 cycle for single-cycle ops, k for SHIFT by k, WIDTH for MUL.
// o_ready drops while an iterative op runs; requests seen then are dropped, not queued.
import alu_pkg::*;

module alu_seq #(
    parameter int WIDTH = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_oper,
    input  logic [WIDTH-1:0] i_arg0,
    input  logic [WIDTH-1:0] i_arg1,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_imm,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flag
);

    state_t           state_q, state_d;
    logic             accept, iter_start, single_wb, iter_wb;
    logic             sh_left, sh_multi, ovf_c, iter_done, iter_ovf;
    logic [WIDTH-1:0] b, sh_mag, sh_k, sum, diff, res_c, iter_res, step1;

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] v, input logic ovf);
        logic [3:0] f;
        f           = '0;
        f[FLG_NEG]  = v[WIDTH-1];
        f[FLG_POS]  = ~v[WIDTH-1] && (v != '0);
        f[FLG_ZERO] = (v == '0);
        f[FLG_OVF]  = ovf;
        return f;
    endfunction

    assign b        = i_imm ? i_data : i_arg1;
    assign sum      = i_arg0 + b;
    assign diff     = i_arg0 - b;
    assign sh_left  = ~b[WIDTH-1];
    assign sh_mag   = b[WIDTH-1] ? -b : b;
    assign sh_k     = (sh_mag > WIDTH'(WIDTH)) ? WIDTH'(WIDTH) : sh_mag;
    assign sh_multi = (sh_k > WIDTH'(1));

    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        case (i_oper)
            OP_ADD: begin
                res_c = sum;
                ovf_c = (i_arg0[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != i_arg0[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                res_c = diff;
                ovf_c = (i_arg0[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != i_arg0[WIDTH-1]);
            end
            // Only k of 0 or 1 completes here; longer shifts go to the iterator.
            OP_SHIFT: res_c = (sh_k == '0) ? i_arg0 : step1;
            OP_AND:   res_c = i_arg0 & b;
            OP_OR:    res_c = i_arg0 | b;
            OP_XOR:   res_c = i_arg0 ^ b;
            default:  res_c = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (i_oper == OP_MUL)                    state_d = MUL;
                    else if (i_oper == OP_SHIFT && sh_multi) state_d = SHIFT;
                end
            end
            SHIFT, MUL: if (iter_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready    = (state_q == IDLE);
        accept     = i_valid && o_ready;
        iter_start = accept && ((i_oper == OP_MUL) || (i_oper == OP_SHIFT && sh_multi));
        single_wb  = accept && !iter_start;
        iter_wb    = (state_q != IDLE) && iter_done;
    end

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (iter_start),
        .i_mul    (i_oper == OP_MUL),
        .i_left   (sh_left),
        .i_a      (i_arg0),
        .i_b      (b),
        .i_steps  ((i_oper == OP_MUL) ? WIDTH'(WIDTH) : sh_k),
        .o_step1  (step1),
        .o_done   (iter_done),
        .o_result (iter_res),
        .o_ovf    (iter_ovf)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_result <= '0;
            o_flag   <= '0;
        end else begin
            o_valid <= single_wb || iter_wb;
            if (single_wb) begin
                if (i_oper != OP_CMP) o_result <= res_c;
                o_flag <= mk_flags(res_c, ovf_c);
            end else if (iter_wb) begin
                o_result <= iter_res;
                o_flag   <= mk_flags(iter_res, iter_ovf);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=6 with hand-computed expected values.
module tb_alu_seq;

    localparam int W = 6;

    logic         i_clk = 1'b0;
    logic         i_rst, i_valid, i_imm, o_ready, o_valid;
    logic [2:0]   i_oper;
    logic [W-1:0] i_arg0, i_arg1, i_data, o_result;
    logic [3:0]   o_flag;
    int           checks = 0;
    int           fails  = 0;

    always #5 i_clk = ~i_clk;

    alu_seq #(.WIDTH(W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_oper(i_oper), .i_arg0(i_arg0), .i_arg1(i_arg1), .i_data(i_data),
        .i_imm(i_imm), .o_valid(o_valid), .o_result(o_result), .o_flag(o_flag)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] bb,
                         input logic imm, input logic [W-1:0] d);
        i_valid = 1'b1; i_oper = op; i_arg0 = a; i_arg1 = bb; i_imm = imm; i_data = d;
    endtask

    task automatic idle();
        i_valid = 1'b0; i_oper = 3'b000; i_arg0 = '0; i_arg1 = '0; i_imm = 1'b0; i_data = '0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        idle();
        tick(); tick();
        checks++; if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_result !== 6'b000000) begin fails++; $display("FAIL reset_result: got %b want 000000", o_result); end
        checks++; if (o_flag !== 4'b0000) begin fails++; $display("FAIL reset_flag: got %b want 0000", o_flag); end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        drive(3'b000, 6'd31, 6'd1, 1'b0, 6'd0);
        tick(); idle();
        checks++; if (o_valid !== 1'b1) begin fails++; $display("FAIL add_valid: got %b want 1", o_valid); end
        checks++; if (o_result !== 6'b100000) begin fails++; $display("FAIL add_result: got %b want 100000", o_result); end
        checks++; if (o_flag !== 4'b1001) begin fails++; $display("FAIL add_flag: got %b want 1001", o_flag); end
        checks++; if (o_ready !== 1'b1) begin fails++; $display("FAIL add_ready: got %b want 1", o_ready); end
        tick();
        checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL add_pulse: got %b want 0", o_valid); end
    endtask

    task automatic test_sub_cmp();
        drive(3'b001, 6'd5, 6'd0, 1'b1, 6'd7);
        tick(); idle();
        checks++; if (o_valid !== 1'b1) begin fails++; $display("FAIL sub_valid: got %b want 1", o_valid); end
        checks++; if (o_result !== 6'b111110) begin fails++; $display("FAIL sub_result: got %b want 111110", o_result); end
        checks++; if (o_flag !== 4'b0001) begin fails++; $display("FAIL sub_flag: got %b want 0001", o_flag); end
        drive(3'b111, 6'd3, 6'd3, 1'b0, 6'd0);
        tick(); idle();
        checks++; if (o_valid !== 1'b1) begin fails++; $display("FAIL cmp_valid: got %b want 1", o_valid); end
        checks++; if (o_flag !== 4'b0100) begin fails++; $display("FAIL cmp_flag: got %b want 0100", o_flag); end
        checks++; if (o_result !== 6'b111110) begin fails++; $display("FAIL cmp_result_held: got %b want 111110", o_result); end
    endtask

    task automatic test_shift();
        drive(3'b010, 6'b111000, 6'b111110, 1'b0, 6'd0);
        tick(); idle();
        checks++; if ({o_ready, o_valid} !== 2'b00) begin fails++; $display("FAIL shr_busy: got rdy/vld %b want 00", {o_ready, o_valid}); end
        tick();
        checks++; if ({o_ready, o_valid} !== 2'b11) begin fails++; $display("FAIL shr_done: got rdy/vld %b want 11", {o_ready, o_valid}); end
        checks++; if (o_result !== 6'b111110) begin fails++; $display("FAIL shr_result: got %b want 111110", o_result); end
        checks++; if (o_flag !== 4'b0001) begin fails++; $display("FAIL shr_flag: got %b want 0001", o_flag); end
        drive(3'b010, 6'd1, 6'd31, 1'b0, 6'd0);
        tick(); idle();
        for (int c = 1; c < 6; c++) begin
            checks++; if ({o_ready, o_valid} !== 2'b00) begin fails++; $display("FAIL shl_busy_c%0d: got rdy/vld %b want 00", c, {o_ready, o_valid}); end
            tick();
        end
        checks++; if (o_valid !== 1'b1) begin fails++; $display("FAIL shl_valid: got %b want 1", o_valid); end
        checks++; if (o_result !== 6'b000000) begin fails++; $display("FAIL shl_result: got %b want 000000", o_result); end
        checks++; if (o_flag !== 4'b0100) begin fails++; $display("FAIL shl_flag: got %b want 0100", o_flag); end
    endtask

    task automatic test_mul();
        logic [W-1:0] a_v [2];
        logic [W-1:0] b_v [2];
        logic [W-1:0] r_v [2];
        logic [3:0]   f_v [2];
        a_v[0] = 6'd7;      b_v[0] = 6'b111011; r_v[0] = 6'b011101; f_v[0] = 4'b1010;
        a_v[1] = 6'b111100; b_v[1] = 6'd3;      r_v[1] = 6'b110100; f_v[1] = 4'b0001;
        for (int t = 0; t < 2; t++) begin
            drive(3'b110, a_v[t], b_v[t], 1'b0, 6'd0);
            tick(); idle();
            for (int c = 1; c < 6; c++) begin
                checks++; if ({o_ready, o_valid} !== 2'b00) begin fails++; $display("FAIL mul%0d_busy_c%0d: got rdy/vld %b want 00", t, c, {o_ready, o_valid}); end
                tick();
            end
            checks++; if (o_valid !== 1'b1) begin fails++; $display("FAIL mul%0d_valid: got %b want 1", t, o_valid); end
            checks++; if (o_result !== r_v[t]) begin fails++; $display("FAIL mul%0d_result: got %b want %b", t, o_result, r_v[t]); end
            checks++; if (o_flag !== f_v[t]) begin fails++; $display("FAIL mul%0d_flag: got %b want %b", t, o_flag, f_v[t]); end
        end
    endtask

    task automatic test_back_to_back();
        drive(3'b101, 6'b101010, 6'b010101, 1'b0, 6'd0);
        tick();
        drive(3'b011, 6'b101010, 6'b010101, 1'b0, 6'd0);
        checks++; if (o_valid !== 1'b1) begin fails++; $display("FAIL xor_valid: got %b want 1", o_valid); end
        checks++; if (o_result !== 6'b111111) begin fails++; $display("FAIL xor_result: got %b want 111111", o_result); end
        checks++; if (o_flag !== 4'b0001) begin fails++; $display("FAIL xor_flag: got %b want 0001", o_flag); end
        tick(); idle();
        checks++; if (o_valid !== 1'b1) begin fails++; $display("FAIL and_valid: got %b want 1", o_valid); end
        checks++; if (o_result !== 6'b000000) begin fails++; $display("FAIL and_result: got %b want 000000", o_result); end
        checks++; if (o_flag !== 4'b0100) begin fails++; $display("FAIL and_flag: got %b want 0100", o_flag); end
        // An ADD held valid while the MUL runs must be dropped.
        drive(3'b110, 6'd2, 6'd3, 1'b0, 6'd0);
        tick();
        drive(3'b000, 6'd1, 6'd1, 1'b0, 6'd0);
        for (int c = 1; c < 5; c++) begin
            checks++; if ({o_ready, o_valid} !== 2'b00) begin fails++; $display("FAIL ign_busy_c%0d: got rdy/vld %b want 00", c, {o_ready, o_valid}); end
            tick();
        end
        idle();
        checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL ign_c5_valid: got %b want 0", o_valid); end
        tick();
        checks++; if (o_valid !== 1'b1) begin fails++; $display("FAIL ign_mul_valid: got %b want 1", o_valid); end
        checks++; if (o_result !== 6'd6) begin fails++; $display("FAIL ign_mul_result: got %b want 000110", o_result); end
        checks++; if (o_flag !== 4'b0010) begin fails++; $display("FAIL ign_mul_flag: got %b want 0010", o_flag); end
        tick();
        checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL ign_extra_valid: got %b want 0", o_valid); end
        checks++; if (o_result !== 6'd6) begin fails++; $display("FAIL ign_result_held: got %b want 000110", o_result); end
    endtask

    task automatic test_reset_mid_mul();
        drive(3'b110, 6'd7, 6'd7, 1'b0, 6'd0);
        tick(); idle();
        tick(); tick();
        i_rst = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b1) begin fails++; $display("FAIL rst_mul_ready: got %b want 1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rst_mul_valid: got %b want 0", o_valid); end
        checks++; if (o_result !== 6'b000000) begin fails++; $display("FAIL rst_mul_result: got %b want 000000", o_result); end
        checks++; if (o_flag !== 4'b0000) begin fails++; $display("FAIL rst_mul_flag: got %b want 0000", o_flag); end
        tick();
        i_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++; if ({o_ready, o_valid} !== 2'b10) begin fails++; $display("FAIL rst_quiet_c%0d: got rdy/vld %b want 10", c, {o_ready, o_valid}); end
            tick();
        end
        drive(3'b000, 6'd2, 6'd2, 1'b0, 6'd0);
        tick(); idle();
        checks++; if (o_valid !== 1'b1) begin fails++; $display("FAIL post_rst_valid: got %b want 1", o_valid); end
        checks++; if (o_result !== 6'd4) begin fails++; $display("FAIL post_rst_result: got %b want 000100", o_result); end
        checks++; if (o_flag !== 4'b0010) begin fails++; $display("FAIL post_rst_flag: got %b want 0010", o_flag); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_cmp();
        test_shift();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
